// File: rtl/encoder83_enable.sv
// Registered 8-to-3 priority encoder with active-low encode enable.
// Reports the highest set request bit, a valid flag and a multiple-request flag.
module encoder83_enable (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       e,
  input  logic [7:0] w,
  output logic [2:0] y,
  output logic       v,
  output logic       multi
);

  logic [2:0] y_next;
  logic       v_next;
  logic       multi_next;
  logic       enabled;

  assign enabled = ~e;

  // Ascending scan so the highest set bit is the last to win.
  always_comb begin
    y_next = 3'd0;
    if (enabled) begin
      for (int i = 0; i < 8; i++) begin
        if (w[i]) begin
          y_next = 3'(i);
        end
      end
    end
  end

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  always_comb begin
    v_next     = enabled & (|w);
    multi_next = enabled & ((w & (w - 8'd1)) != 8'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= 3'd0;
      v     <= 1'b0;
      multi <= 1'b0;
    end else begin
      y     <= y_next;
      v     <= v_next;
      multi <= multi_next;
    end
  end

endmodule

// File: tb/tb_encoder83_enable.sv
// Directed self-checking bench for encoder83_enable.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_encoder83_enable;

  logic       clk;
  logic       rst_n;
  logic       e;
  logic [7:0] w;
  logic [2:0] y;
  logic       v;
  logic       multi;

  int check_count = 0;
  int pass_count  = 0;

  encoder83_enable dut (
    .clk   (clk),
    .rst_n (rst_n),
    .e     (e),
    .w     (w),
    .y     (y),
    .v     (v),
    .multi (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    e     = 1'b0;
    w     = 8'h80;
    #2;
    check_count++;
    if ({y, v, multi} !== 5'b000_0_0)
      $display("FAIL reset_async: got y=%0d v=%0b multi=%0b, expected y=0 v=0 multi=0", y, v, multi);
    else pass_count++;
    tick();
    tick();
    check_count++;
    if ({y, v, multi} !== 5'b000_0_0)
      $display("FAIL reset_held: got y=%0d v=%0b multi=%0b, expected y=0 v=0 multi=0", y, v, multi);
    else pass_count++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_count++;
    if ({y, v, multi} !== 5'b111_1_0)
      $display("FAIL reset_release: got y=%0d v=%0b multi=%0b, expected y=7 v=1 multi=0", y, v, multi);
    else pass_count++;
  endtask

  task automatic test_one_hot();
    logic [2:0] prev_y;
    e = 1'b0;
    for (int k = 0; k < 8; k++) begin
      prev_y = y;
      w = 8'd1 << k;
      #1;
      check_count++;
      if (y !== prev_y)
        $display("FAIL one_hot_latency_%0d: got y=%0d, expected unchanged y=%0d before edge", k, y, prev_y);
      else pass_count++;
      tick();
      check_count++;
      if ({y, v, multi} !== {3'(k), 1'b1, 1'b0})
        $display("FAIL one_hot_%0d: got y=%0d v=%0b multi=%0b, expected y=%0d v=1 multi=0", k, y, v, multi, k);
      else pass_count++;
    end
  endtask

  task automatic test_zero();
    e = 1'b0;
    w = 8'h00;
    tick();
    check_count++;
    if ({y, v, multi} !== 5'b000_0_0)
      $display("FAIL zero_input: got y=%0d v=%0b multi=%0b, expected y=0 v=0 multi=0", y, v, multi);
    else pass_count++;
  endtask

  task automatic test_disabled();
    e = 1'b1;
    w = 8'h01;
    tick();
    check_count++;
    if ({y, v, multi} !== 5'b000_0_0)
      $display("FAIL disabled_01: got y=%0d v=%0b multi=%0b, expected y=0 v=0 multi=0", y, v, multi);
    else pass_count++;
    w = 8'hFF;
    tick();
    check_count++;
    if ({y, v, multi} !== 5'b000_0_0)
      $display("FAIL disabled_ff: got y=%0d v=%0b multi=%0b, expected y=0 v=0 multi=0", y, v, multi);
    else pass_count++;
    e = 1'b0;
    w = 8'h01;
    tick();
    check_count++;
    if ({y, v, multi} !== 5'b000_1_0)
      $display("FAIL enable_01: got y=%0d v=%0b multi=%0b, expected y=0 v=1 multi=0", y, v, multi);
    else pass_count++;
    e = 1'b1;
    tick();
    check_count++;
    if ({y, v, multi} !== 5'b000_0_0)
      $display("FAIL disable_held_w: got y=%0d v=%0b multi=%0b, expected y=0 v=0 multi=0", y, v, multi);
    else pass_count++;
  endtask

  task automatic test_priority_multi();
    e = 1'b0;
    w = 8'b0010_0110;
    tick();
    check_count++;
    if ({y, v, multi} !== 5'b101_1_1)
      $display("FAIL priority_26: got y=%0d v=%0b multi=%0b, expected y=5 v=1 multi=1", y, v, multi);
    else pass_count++;
    w = 8'hFF;
    tick();
    check_count++;
    if ({y, v, multi} !== 5'b111_1_1)
      $display("FAIL priority_ff: got y=%0d v=%0b multi=%0b, expected y=7 v=1 multi=1", y, v, multi);
    else pass_count++;
  endtask

  task automatic test_async_reset_mid();
    e = 1'b0;
    for (int k = 0; k < 8; k++) begin
      w = 8'd1 << k;
      tick();
      if (k == 3) begin
        rst_n = 1'b0;
        #1;
        check_count++;
        if ({y, v, multi} !== 5'b000_0_0)
          $display("FAIL mid_reset_clear: got y=%0d v=%0b multi=%0b, expected y=0 v=0 multi=0", y, v, multi);
        else pass_count++;
        rst_n = 1'b1;
        #1;
      end else begin
        check_count++;
        if ({y, v, multi} !== {3'(k), 1'b1, 1'b0})
          $display("FAIL mid_sweep_%0d: got y=%0d v=%0b multi=%0b, expected y=%0d v=1 multi=0", k, y, v, multi, k);
        else pass_count++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       vec_e   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] vec_w   [6] = '{8'h03, 8'h10, 8'h10, 8'h00, 8'h41, 8'h80};
    logic [4:0] vec_exp [6] = '{5'b001_1_1, 5'b100_1_0, 5'b000_0_0,
                                5'b000_0_0, 5'b110_1_1, 5'b111_1_0};
    for (int i = 0; i < 6; i++) begin
      e = vec_e[i];
      w = vec_w[i];
      tick();
      check_count++;
      if ({y, v, multi} !== vec_exp[i])
        $display("FAIL back_to_back_%0d: got {y,v,multi}=%b, expected %b", i, {y, v, multi}, vec_exp[i]);
      else pass_count++;
    end
  endtask

  initial begin
    test_reset();
    test_one_hot();
    test_zero();
    test_disabled();
    test_priority_multi();
    test_async_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
